sp_ram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the single-port RAM.

---
 rtl/sp_ram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
//   Round-robin arbiter and sequencer that lets two requesters share one
//   single-port RAM. One read or write is accepted per cycle. The winner's
//   command is registered onto the RAM bus. Read data is routed back to the
//   requester that issued the read, in issue order.
//
// Ports
//   clock, reset          clock; asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (bit i = requester i)
//   req_we                1 = write, 0 = read
//   req_addr0/1           request address per requester
//   req_wdata0/1          write data per requester
//   rsp_valid             one-hot read-response strobe (no backpressure)
//   rsp_rdata             read data, qualified by rsp_valid
//   ram_*                 RAM command bus and read data return
//   o_dbg_state           arbiter state (0 = LAST0, 1 = LAST1)
//
// Handshake: a request transfers on a rising clock edge where
//   req_valid[i] && req_ready[i]. The requester keeps valid, we, addr and
//   wdata stable until that edge. req_ready is combinational from req_valid
//   and the arbiter state, and it has at most one bit set. Responses cannot
//   be stalled, so a requester must accept rsp_valid whenever it is high.
module sp_ram_arbiter #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    parameter  int RD_LAT = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [WIDTH-1:0]  req_wdata0,
    input  logic [WIDTH-1:0]  req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WIDTH-1:0]  ram_data_in,
    input  logic [WIDTH-1:0]  ram_data_out,
    output logic              o_dbg_state
);

    // State records which requester received the most recent grant.
    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        w_grant;
    logic              w_fire;
    logic              w_win_id;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [WIDTH-1:0]  w_win_wdata;

    // Stage k holds the tag of a read that was accepted k+1 edges ago.
    // The last stage lines up with the cycle where ram_data_out is valid.
    tag_t              r_tag [RD_LAT+1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= LAST1;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grants are forced to zero while reset is asserted, so that nothing
    // appears to be accepted during reset.
    always_comb begin
        w_grant      = 2'b00;
        w_next_state = r_state;
        if (reset) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = (r_state == LAST1) ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
            if (w_grant[0]) begin
                w_next_state = LAST0;
            end else if (w_grant[1]) begin
                w_next_state = LAST1;
            end
        end
    end

    assign req_ready   = w_grant;
    assign o_dbg_state = r_state;

    assign w_fire      = |w_grant;
    assign w_win_id    = w_grant[1];
    assign w_win_we    = w_win_id ? req_we[1]  : req_we[0];
    assign w_win_addr  = w_win_id ? req_addr1  : req_addr0;
    assign w_win_wdata = w_win_id ? req_wdata1 : req_wdata0;

    // Command stage: address and data hold their last values when the bus
    // is idle. Only the enables return to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ram_write_enable <= 1'b0;
            ram_read_enable  <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
        end else begin
            ram_write_enable <= w_fire & w_win_we;
            ram_read_enable  <= w_fire & ~w_win_we;
            if (w_fire) begin
                ram_address <= w_win_addr;
                ram_data_in <= w_win_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_fire & ~w_win_we;
            r_tag[0].id    <= w_win_id;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // rsp_rdata only loads when a tagged read is present, so between
    // responses it holds the last returned word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= {r_tag[RD_LAT].valid & r_tag[RD_LAT].id,
                          r_tag[RD_LAT].valid & ~r_tag[RD_LAT].id};
            if (r_tag[RD_LAT].valid) begin
                rsp_rdata <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter
//   Bench for sp_ram_arbiter. A behavioural RAM sits on the command bus.
//   A reference model runs at every falling edge and tracks four things:
//   the last winner, a shadow memory, the expected RAM command, and a
//   queue of pending read responses, each with the cycle it is due.
module tb_sp_ram_arbiter;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 1;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [WIDTH-1:0]  req_wdata0;
    logic [WIDTH-1:0]  req_wdata1;
    logic [1:0]        rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              ram_write_enable;
    logic              ram_read_enable;
    logic [ADDR_W-1:0] ram_address;
    logic [WIDTH-1:0]  ram_data_in;
    logic [WIDTH-1:0]  ram_data_out;
    logic              o_dbg_state;

    sp_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr0        (req_addr0),
        .req_addr1        (req_addr1),
        .req_wdata0       (req_wdata0),
        .req_wdata1       (req_wdata1),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out),
        .o_dbg_state      (o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- behavioural RAM (RD_LAT = 1) ----------------
    logic [WIDTH-1:0] ram_mem [DEPTH];
    always @(posedge clock) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
        if (ram_read_enable)  ram_data_out <= ram_mem[ram_address];
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [WIDTH:0]    exp_q[$];   // {requester id, data}
    int                due_q[$];   // cycle in which that response is due
    logic [WIDTH-1:0]  shadow [DEPTH];
    int                cyc = 0;
    int                last_win = 1;
    logic              cmd_we = 1'b0;
    logic              cmd_re = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [WIDTH-1:0]  exp_din = '0;
    int                m_win;
    logic [1:0]        m_ready;
    logic [WIDTH:0]    m_ent;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [WIDTH-1:0]  m_data;

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            exp_q.delete();
            due_q.delete();
            last_win = 1;
            cmd_we   = 1'b0;
            cmd_re   = 1'b0;
            exp_addr = '0;
            exp_din  = '0;
            check_eq("rst_req_ready", 32'(req_ready), 32'(0));
            check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
            check_eq("rst_ram_we", 32'(ram_write_enable), 32'(0));
            check_eq("rst_ram_re", 32'(ram_read_enable), 32'(0));
            check_eq("rst_ram_addr", 32'(ram_address), 32'(0));
            check_eq("rst_ram_din", 32'(ram_data_in), 32'(0));
        end else begin
            // The command accepted at the previous edge must be on the RAM bus now.
            check_eq("ram_we", 32'(ram_write_enable), 32'(cmd_we));
            check_eq("ram_re", 32'(ram_read_enable), 32'(cmd_re));
            check_eq("ram_addr", 32'(ram_address), 32'(exp_addr));
            check_eq("ram_din", 32'(ram_data_in), 32'(exp_din));

            if (due_q.size() != 0 && due_q[0] == cyc) begin
                m_ent = exp_q.pop_front();
                void'(due_q.pop_front());
                check_eq("rsp_valid", 32'(rsp_valid), m_ent[WIDTH] ? 32'd2 : 32'd1);
                check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_ent[WIDTH-1:0]));
            end else begin
                check_eq("rsp_idle", 32'(rsp_valid), 32'(0));
            end

            // Round robin: a lone requester wins; when both are valid,
            // the one that did not win last time wins.
            if (req_valid == 2'b11)  m_win = 1 - last_win;
            else if (req_valid[0])   m_win = 0;
            else if (req_valid[1])   m_win = 1;
            else                     m_win = -1;
            m_ready = (m_win < 0) ? 2'b00 : ((m_win == 1) ? 2'b10 : 2'b01);
            check_eq("req_ready", 32'(req_ready), 32'(m_ready));

            if (m_win >= 0) begin
                last_win = m_win;
                m_we   = req_we[m_win];
                m_addr = (m_win == 1) ? req_addr1 : req_addr0;
                m_data = (m_win == 1) ? req_wdata1 : req_wdata0;
                if (m_we) begin
                    shadow[m_addr] = m_data;
                end else begin
                    exp_q.push_back({m_win[0], shadow[m_addr]});
                    due_q.push_back(cyc + 2 + RD_LAT);
                end
                cmd_we   = m_we;
                cmd_re   = !m_we;
                exp_addr = m_addr;
                exp_din  = m_data;
            end else begin
                cmd_we = 1'b0;
                cmd_re = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input int id, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [WIDTH-1:0] d);
        int waited;
        waited = 0;
        if (id == 0) begin
            req_addr0  = a;
            req_wdata0 = d;
        end else begin
            req_addr1  = a;
            req_wdata1 = d;
        end
        req_we[id]    = we;
        req_valid[id] = 1'b1;
        forever begin
            @(negedge clock);
            if (req_ready[id]) break;
            waited++;
            if (waited > 40) begin
                check_eq("ready_timeout", 32'(req_ready[id]), 32'(1));
                break;
            end
        end
        @(posedge clock);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic random_traffic(input int id, input int n);
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                repeat (gap) @(posedge clock);
                #1;
            end
            issue(id, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH-1)),
                  WIDTH'($urandom_range(0, 255)));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_we     = 2'b00;
        req_addr0  = '0;
        req_addr1  = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        #2 reset = 1'b0;

        // Reset with traffic pending on both requesters.
        idle(2);
        req_addr0  = ADDR_W'($urandom_range(0, DEPTH-1));
        req_addr1  = ADDR_W'($urandom_range(0, DEPTH-1));
        req_wdata0 = WIDTH'($urandom_range(0, 255));
        req_wdata1 = WIDTH'($urandom_range(0, 255));
        req_we     = 2'b11;
        req_valid  = 2'b11;
        idle(3);
        reset     = 1'b1;
        req_valid = 2'b00;
        fork
            issue(0, 1'b1, ADDR_W'($urandom_range(0, DEPTH-1)), WIDTH'($urandom_range(0, 255)));
            issue(1, 1'b1, ADDR_W'($urandom_range(0, DEPTH-1)), WIDTH'($urandom_range(0, 255)));
        join

        // Fill every word so later reads have known contents.
        for (int a = 0; a < DEPTH; a++) begin
            issue(0, 1'b1, ADDR_W'(a), WIDTH'($urandom_range(0, 255)));
        end

        // Single write then read.
        issue(0, 1'b1, ADDR_W'(3), 8'hA5);
        issue(0, 1'b0, ADDR_W'(3), 8'h00);
        idle(5);

        // Contention: both requesters read continuously.
        fork
            begin repeat (3) issue(0, 1'b0, ADDR_W'(1), 8'h00); end
            begin repeat (3) issue(1, 1'b0, ADDR_W'(2), 8'h00); end
        join
        idle(5);

        // Back-to-back reads across the whole address space.
        for (int a = 0; a < DEPTH; a++) begin
            issue(1, 1'b0, ADDR_W'(a), 8'h00);
        end
        idle(5);

        // Read immediately after a write to the same address.
        issue(0, 1'b1, ADDR_W'(7), 8'h3C);
        issue(1, 1'b0, ADDR_W'(7), 8'h00);
        idle(5);

        // Random mixed traffic.
        fork
            random_traffic(0, 60);
            random_traffic(1, 60);
        join
        idle(6);

        // Reset one cycle after a read is accepted: its response is dropped.
        issue(0, 1'b0, ADDR_W'($urandom_range(0, DEPTH-1)), 8'h00);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        fork
            issue(0, 1'b0, ADDR_W'($urandom_range(0, DEPTH-1)), 8'h00);
            issue(1, 1'b0, ADDR_W'($urandom_range(0, DEPTH-1)), 8'h00);
        join

        fork
            random_traffic(0, 40);
            random_traffic(1, 40);
        join
        idle(8);

        check_eq("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
